// File: rtl/simple_bus.sv
// Host-to-device interconnect: fixed-priority arbitration, base/mask address decode,
// and response routing one cycle after the grant.
module simple_bus #(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,

  input  logic [NrHosts-1:0]                       host_req_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic [NrHosts-1:0]                       host_err_o,

  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  input  logic [NrDevices-1:0]                     device_err_i,

  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic                    host_found;
  logic [HostIdxW-1:0]     host_sel;
  logic                    dev_found;
  logic [DevIdxW-1:0]      dev_sel;
  logic [AddressWidth-1:0] win_addr;

  logic                    pending_q;
  logic                    unmapped_q;
  logic [HostIdxW-1:0]     host_q;
  logic [DevIdxW-1:0]      dev_q;

  // Lowest-index requesting host wins; host 0 is the default when idle.
  always_comb begin
    host_found = 1'b0;
    host_sel   = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (host_req_i[h] && !host_found) begin
        host_found = 1'b1;
        host_sel   = HostIdxW'(h);
      end
    end
  end

  assign win_addr = host_addr_i[host_sel];

  // Lowest-index device whose masked base matches the winner's address.
  always_comb begin
    dev_found = 1'b0;
    dev_sel   = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) && !dev_found) begin
        dev_found = 1'b1;
        dev_sel   = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    host_gnt_o = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = host_found && (host_sel == HostIdxW'(h));
    end
  end

  // Winner's fields are broadcast; only the decoded device sees a request.
  always_comb begin
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = host_found && dev_found && (dev_sel == DevIdxW'(d));
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = host_we_i[host_sel];
      device_be_o[d]    = host_be_i[host_sel];
      device_wdata_o[d] = host_wdata_i[host_sel];
    end
  end

  // Remember who was granted so the response next cycle can be steered back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      unmapped_q <= 1'b0;
      host_q     <= '0;
      dev_q      <= '0;
    end else begin
      pending_q <= host_found;
      if (host_found) begin
        host_q     <= host_sel;
        dev_q      <= dev_sel;
        unmapped_q <= !dev_found;
      end
    end
  end

  // Unmapped accesses complete with an error and zero data instead of a device reply.
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (pending_q && (host_q == HostIdxW'(h))) begin
        if (unmapped_q) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
          host_rvalid_o[h] = device_rvalid_i[dev_q];
          host_rdata_o[h]  = device_rdata_i[dev_q];
          host_err_o[h]    = device_err_i[dev_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Directed bench for simple_bus with two hosts and four devices (RAM, sim ctrl, timer, accel).
module tb_simple_bus;

  localparam int unsigned NH = 2;
  localparam int unsigned ND = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NH-1:0]        host_req = '0;
  logic [NH-1:0]        host_gnt;
  logic [NH-1:0][31:0]  host_addr = '0;
  logic [NH-1:0]        host_we = '0;
  logic [NH-1:0][3:0]   host_be = '0;
  logic [NH-1:0][31:0]  host_wdata = '0;
  logic [NH-1:0]        host_rvalid;
  logic [NH-1:0][31:0]  host_rdata;
  logic [NH-1:0]        host_err;
  logic [ND-1:0]        dev_req;
  logic [ND-1:0][31:0]  dev_addr;
  logic [ND-1:0]        dev_we;
  logic [ND-1:0][3:0]   dev_be;
  logic [ND-1:0][31:0]  dev_wdata;
  logic [ND-1:0]        dev_rvalid = '0;
  logic [ND-1:0][31:0]  dev_rdata = '0;
  logic [ND-1:0]        dev_err = '0;
  logic [ND-1:0][31:0]  cfg_base;
  logic [ND-1:0][31:0]  cfg_mask;

  int checks = 0;
  int errors = 0;

  assign cfg_base[0] = 32'h0010_0000; assign cfg_mask[0] = ~32'h000F_FFFF;
  assign cfg_base[1] = 32'h0002_0000; assign cfg_mask[1] = 32'hFFFF_0000;
  assign cfg_base[2] = 32'h0003_0000; assign cfg_mask[2] = 32'hFFFF_0000;
  assign cfg_base[3] = 32'h0004_0000; assign cfg_mask[3] = 32'hFFFF_0000;

  simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  always #5 clk = ~clk;

  // Device models: reply one cycle after req; data tags the device and low address bits; dev3 errors.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] <= dev_req[d];
      dev_rdata[d]  <= 32'hC0DE_0000 | (32'(d) << 12) | {20'h0, dev_addr[d][11:0]};
      dev_err[d]    <= (d == 3) && dev_req[d];
    end
  end

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic        we0, we1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    logic [1:0]  gnt;
    logic [3:0]  dreq;
    logic [31:0] baddr;
    logic        bwe;
    logic [3:0]  bbe;
    logic [31:0] bwd;
    logic [1:0]  rvalid, err;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [1:0] rv, input logic [1:0] er,
                          input logic [31:0] rd0, input logic [31:0] rd1);
    chk({tag, ".rvalid"}, 32'(host_rvalid), 32'(rv));
    chk({tag, ".err"}, 32'(host_err), 32'(er));
    chk({tag, ".rdata0"}, host_rdata[0], rd0);
    chk({tag, ".rdata1"}, host_rdata[1], rd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req    a0            a1            we0 we1 be0   be1   wd0           wd1
    //          gnt    dreq    baddr          bwe bbe   bwd            rvalid err   rd0           rd1
    vecs[0] = '{2'b10, 32'h0000_0000, 32'h0010_0004, 1'b0, 1'b0, 4'hF, 4'hF, 32'h1111_1111, 32'h2222_2222,
                2'b10, 4'b0001, 32'h0010_0004, 1'b0, 4'hF, 32'h2222_2222, 2'b10, 2'b00, 32'h0, 32'hC0DE_0004};
    vecs[1] = '{2'b01, 32'h0004_0010, 32'h0010_0004, 1'b1, 1'b0, 4'h3, 4'hF, 32'hDEAD_BEEF, 32'h2222_2222,
                2'b01, 4'b1000, 32'h0004_0010, 1'b1, 4'h3, 32'hDEAD_BEEF, 2'b01, 2'b01, 32'hC0DE_3010, 32'h0};
    vecs[2] = '{2'b01, 32'h0000_0000, 32'h0003_0000, 1'b0, 1'b1, 4'hF, 4'h1, 32'h0, 32'h5,
                2'b01, 4'b0000, 32'h0000_0000, 1'b0, 4'hF, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0};
    vecs[3] = '{2'b00, 32'h1234_5678, 32'h0003_0000, 1'b1, 1'b0, 4'h6, 4'hF, 32'hCAFE_F00D, 32'h1,
                2'b00, 4'b0000, 32'h1234_5678, 1'b1, 4'h6, 32'hCAFE_F00D, 2'b00, 2'b00, 32'h0, 32'h0};
    vecs[4] = '{2'b11, 32'h0010_0FF0, 32'h0004_0000, 1'b0, 1'b1, 4'hF, 4'hC, 32'h0, 32'h7,
                2'b01, 4'b0001, 32'h0010_0FF0, 1'b0, 4'hF, 32'h0, 2'b01, 2'b00, 32'hC0DE_0FF0, 32'h0};
    vecs[5] = '{2'b10, 32'h0002_0000, 32'h0004_FFFC, 1'b1, 1'b0, 4'h1, 4'hF, 32'h9, 32'hABCD_0123,
                2'b10, 4'b1000, 32'h0004_FFFC, 1'b0, 4'hF, 32'hABCD_0123, 2'b10, 2'b10, 32'h0, 32'hC0DE_3FFC};

    // Reset state
    #12;
    chk("reset.gnt", 32'(host_gnt), 32'h0);
    chk("reset.dreq", 32'(dev_req), 32'h0);
    chk_resp("reset", 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single transactions with an idle response cycle after each
    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      host_req      = vecs[i].req;
      host_addr[0]  = vecs[i].a0;  host_addr[1]  = vecs[i].a1;
      host_we[0]    = vecs[i].we0; host_we[1]    = vecs[i].we1;
      host_be[0]    = vecs[i].be0; host_be[1]    = vecs[i].be1;
      host_wdata[0] = vecs[i].wd0; host_wdata[1] = vecs[i].wd1;
      #1;
      chk({tag, ".gnt"}, 32'(host_gnt), 32'(vecs[i].gnt));
      chk({tag, ".dreq"}, 32'(dev_req), 32'(vecs[i].dreq));
      chk({tag, ".addr3"}, dev_addr[3], vecs[i].baddr);
      chk({tag, ".addr0"}, dev_addr[0], vecs[i].baddr);
      chk({tag, ".we"}, 32'(dev_we[2]), 32'(vecs[i].bwe));
      chk({tag, ".be"}, 32'(dev_be[1]), 32'(vecs[i].bbe));
      chk({tag, ".wdata"}, dev_wdata[3], vecs[i].bwd);
      tick();
      host_req = '0;
      #1;
      chk_resp(tag, vecs[i].rvalid, vecs[i].err, vecs[i].rd0, vecs[i].rd1);
      tick();
    end

    // Contention: host0 wins, host1 keeps requesting and gets the next cycle
    host_req = 2'b11; host_addr[0] = 32'h0002_0000; host_addr[1] = 32'h0003_0000;
    host_we = '0; host_be = '1;
    #1;
    chk("arb.gnt", 32'(host_gnt), 32'b01);
    chk("arb.dreq", 32'(dev_req), 32'b0010);
    tick();
    host_req = 2'b10;
    #1;
    chk("arb.gnt2", 32'(host_gnt), 32'b10);
    chk("arb.dreq2", 32'(dev_req), 32'b0100);
    chk_resp("arb.r0", 2'b01, 2'b00, 32'hC0DE_1000, 32'h0);
    tick();
    host_req = '0;
    #1;
    chk_resp("arb.r1", 2'b10, 2'b00, 32'h0, 32'hC0DE_2000);
    tick();

    // Back-to-back host1 reads: dev0 then dev2
    host_req = 2'b10; host_addr[1] = 32'h0010_0004;
    #1;
    chk("b2b.gnt", 32'(host_gnt), 32'b10);
    tick();
    host_addr[1] = 32'h0003_0000;
    #1;
    chk("b2b.dreq2", 32'(dev_req), 32'b0100);
    chk_resp("b2b.r0", 2'b10, 2'b00, 32'h0, 32'hC0DE_0004);
    tick();
    host_req = '0;
    #1;
    chk_resp("b2b.r1", 2'b10, 2'b00, 32'h0, 32'hC0DE_2000);
    tick();
    chk_resp("b2b.idle", 2'b00, 2'b00, 32'h0, 32'h0);

    // Reset asserted between grant and response drops the transaction
    host_req = 2'b10; host_addr[1] = 32'h0010_0004;
    #1;
    chk("rst.gnt", 32'(host_gnt), 32'b10);
    tick();
    rst_n = 1'b0; host_req = '0;
    #1;
    chk_resp("rst.mid", 2'b00, 2'b00, 32'h0, 32'h0);
    chk("rst.gnt_off", 32'(host_gnt), 32'h0);
    tick();
    chk_resp("rst.held", 2'b00, 2'b00, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_resp("rst.after", 2'b00, 2'b00, 32'h0, 32'h0);
    chk("rst.dreq", 32'(dev_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
